// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared state type, ratio codes and ratio helpers for the CIC comb sequencer
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } cic_state_e;

  localparam logic [2:0] OS_OFF = 3'b000;
  localparam logic [2:0] OS_MIN = 3'b001;
  localparam logic [2:0] OS_MAX = 3'b110;

  // Decimation ratio R = 2^code; 8 bits so code 7 cannot wrap to zero.
  function automatic logic [7:0] os_ratio(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

  function automatic logic os_legal(input logic [2:0] code);
    return (code >= OS_MIN) && (code <= OS_MAX);
  endfunction

endpackage

// File: rtl/cic_dec_cnt.sv
// rtl/cic_dec_cnt.sv - decimation counter producing one registered comb_en per R input samples
module cic_dec_cnt
  import cic_pkg::*;
#(
  parameter int CNTW = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [2:0] ratio,
  output logic       comb_en
);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] last;

  assign last = CNTW'(os_ratio(ratio) - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      comb_en <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      comb_en <= 1'b0;
    end else if (inc) begin
      if (cnt == last) begin
        cnt     <= '0;
        comb_en <= 1'b1;
      end else begin
        cnt     <= cnt + CNTW'(1);
        comb_en <= 1'b0;
      end
    end else begin
      comb_en <= 1'b0;
    end
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - CIC comb chain sequencer: ratio config, flush/settle and output qualification
module cic_dec_ctrl
  import cic_pkg::*;
#(
  parameter int NSTG      = 3,
  parameter int DM        = 1,
  parameter int FLUSH_CYC = 4,
  parameter int CNTW      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       cfg_req,
  input  logic [2:0] cfg_os_sel,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       in_valid,
  output logic [2:0] os_sel,
  output logic       comb_en,
  output logic       out_valid,
  output logic       busy,
  output logic [1:0] state
);

  localparam int SETTLE_N = NSTG * DM;
  localparam int FW       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int SW       = $clog2(SETTLE_N + 1);

  cic_state_e      state_q;
  cic_state_e      state_d;
  logic [2:0]      ratio_q;
  logic [FW-1:0]   flush_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            cfg_legal;
  logic            flush_done;
  logic            settle_done;
  logic            in_chain;
  logic            next_chain;
  logic            cnt_clr;

  assign cfg_legal   = cfg_req && os_legal(cfg_os_sel);
  assign flush_done  = (flush_cnt == FW'(FLUSH_CYC - 1));
  assign settle_done = comb_en && (settle_cnt == SW'(SETTLE_N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable wins over everything, then a legal request restarts the flush.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else if (cfg_legal) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (ratio_q != OS_OFF) state_d = FLUSH;
        FLUSH:   if (flush_done) state_d = SETTLE;
        SETTLE:  if (settle_done) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    os_sel = OS_OFF;
    busy   = 1'b0;
    case (state_q)
      FLUSH: begin
        busy = 1'b1;
      end
      SETTLE: begin
        busy   = 1'b1;
        os_sel = ratio_q;
      end
      RUN: begin
        os_sel = ratio_q;
      end
      default: begin
        os_sel = OS_OFF;
      end
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
    end else if (state_q == FLUSH && state_d == FLUSH && !cfg_legal) begin
      flush_cnt <= flush_cnt + FW'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (state_q == SETTLE && state_d == SETTLE) begin
      settle_cnt <= settle_cnt + SW'(comb_en);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Clearing on the way out keeps a wrap pending at exit from leaking into FLUSH.
  assign in_chain   = (state_q == SETTLE) || (state_q == RUN);
  assign next_chain = (state_d == SETTLE) || (state_d == RUN);
  assign cnt_clr    = !(in_chain && next_chain);

  cic_dec_cnt #(
    .CNTW (CNTW)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (in_valid),
    .ratio   (ratio_q),
    .comb_en (comb_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_q   <= OS_OFF;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_ack <= cfg_req;
      if (cfg_req) begin
        cfg_err <= !os_legal(cfg_os_sel);
      end
      if (cfg_legal) begin
        ratio_q <= cfg_os_sel;
      end
      out_valid <= comb_en && (state_q == RUN) && en && !cfg_legal;
    end
  end

  a_comb_in_chain: assert property (@(posedge clk) disable iff (!reset_n)
    comb_en |-> (state_q == SETTLE || state_q == RUN));

  a_os_stable_run: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == RUN && $past(state_q) == RUN) |-> $stable(os_sel));

  a_valid_from_run: assert property (@(posedge clk) disable iff (!reset_n)
    out_valid |-> $past(state_q == RUN));

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - self-checking bench for cic_dec_ctrl against a sample-counting reference model
module tb_cic_dec_ctrl;

  localparam int NSTG      = 3;
  localparam int DM        = 1;
  localparam int FLUSH_CYC = 4;
  localparam int CNTW      = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_req = 1'b0;
  logic [2:0] cfg_os_sel = 3'b000;
  logic       in_valid = 1'b0;
  logic       cfg_ack, cfg_err, comb_en, out_valid, busy;
  logic [2:0] os_sel;
  logic [1:0] state;
  logic [9:0] dut_vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit iv_ph = 1'b0;

  // Reference model: phase 0..3, samples seen since the chain started, pulses seen in settle.
  int m_st, m_ratio, m_flush, m_ivs, m_pulses;
  bit m_comb, m_ov, m_ack, m_err;

  assign dut_vec = {state, os_sel, comb_en, out_valid, busy, cfg_ack, cfg_err};

  always #5 clk = ~clk;

  cic_dec_ctrl #(
    .NSTG      (NSTG),
    .DM        (DM),
    .FLUSH_CYC (FLUSH_CYC),
    .CNTW      (CNTW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .cfg_req    (cfg_req),
    .cfg_os_sel (cfg_os_sel),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .os_sel     (os_sel),
    .comb_en    (comb_en),
    .out_valid  (out_valid),
    .busy       (busy),
    .state      (state)
  );

  task automatic model_reset();
    m_st = 0; m_ratio = 0; m_flush = 0; m_ivs = 0; m_pulses = 0;
    m_comb = 0; m_ov = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step(input logic e, input logic r, input logic [2:0] c, input logic v);
    bit legal;
    bit running;
    bit ncomb;
    int nst;
    legal = r && (c >= 3'd1) && (c <= 3'd6);
    if (!e) nst = 0;
    else if (legal) nst = 1;
    else if (m_st == 0) nst = (m_ratio != 0) ? 1 : 0;
    else if (m_st == 1) nst = (m_flush + 1 == FLUSH_CYC) ? 2 : 1;
    else if (m_st == 2) nst = (m_comb && (m_pulses + 1 == NSTG * DM)) ? 3 : 2;
    else nst = 3;
    running  = (m_st >= 2) && (nst >= 2);
    ncomb    = running && v && (((m_ivs + 1) % (1 << m_ratio)) == 0);
    m_ov     = m_comb && (m_st == 3) && e && !legal;
    m_ivs    = running ? m_ivs + int'(v) : 0;
    m_pulses = (m_st == 2 && nst == 2) ? m_pulses + int'(m_comb) : 0;
    m_flush  = (m_st == 1 && nst == 1 && !legal) ? m_flush + 1 : 0;
    m_comb   = ncomb;
    m_ack    = r;
    if (r) m_err = !legal;
    if (legal) m_ratio = int'(c);
    m_st = nst;
  endtask

  function automatic logic [9:0] exp_vec();
    logic [2:0] os;
    os = (m_st >= 2) ? 3'(m_ratio) : 3'b000;
    return {2'(m_st), os, m_comb, m_ov, (m_st == 1 || m_st == 2), m_ack, m_err};
  endfunction

  task automatic step(input logic e, input logic r, input logic [2:0] c, input logic v);
    en = e; cfg_req = r; cfg_os_sel = c; in_valid = v;
    @(posedge clk);
    model_step(e, r, c, v);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 10'b0) begin failures++; $display("FAIL reset_vals got=%b exp=%b", dut_vec, 10'b0); end
    #2 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 3'b000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_flush_settle();
    int n_comb, last_c;
    bit prev_c, got_ov;
    n_comb = 0; last_c = 0; prev_c = 0; got_ov = 0;
    step(1'b1, 1'b1, 3'b010, 1'b0);
    checks++;
    if (cfg_ack !== 1'b1) begin failures++; $display("FAIL t1_ack got=%b exp=1", cfg_ack); end
    for (int i = 0; i < FLUSH_CYC; i++) begin
      if (i > 0) step(1'b1, 1'b0, 3'b000, 1'b1);
      checks++;
      if (state !== 2'd1 || os_sel !== 3'b000) begin
        failures++; $display("FAIL t1_flush i=%0d state=%0d os_sel=%b exp state=1 os_sel=000", i, state, os_sel);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t1_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
    end
    step(1'b1, 1'b0, 3'b000, 1'b1);
    checks++;
    if (state !== 2'd2 || os_sel !== 3'b010) begin
      failures++; $display("FAIL t1_settle state=%0d os_sel=%b exp state=2 os_sel=010", state, os_sel);
    end
    for (int i = 0; i < 40 && !got_ov; i++) begin
      step(1'b1, 1'b0, 3'b000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t1_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      if (out_valid === 1'b1) begin
        got_ov = 1;
        checks++;
        if (n_comb != 4 || !prev_c) begin
          failures++; $display("FAIL t1_first_ov combs=%0d prev_comb=%0d exp combs=4 prev_comb=1", n_comb, prev_c);
        end
      end
      if (comb_en === 1'b1) begin
        if (n_comb > 0) begin
          checks++;
          if (cyc - last_c != 4) begin failures++; $display("FAIL t1_period got=%0d exp=4", cyc - last_c); end
        end
        n_comb++;
        last_c = cyc;
      end
      prev_c = (comb_en === 1'b1);
    end
    checks++;
    if (!got_ov) begin failures++; $display("FAIL t1_ov_timeout got=0 exp=1"); end
  endtask

  task automatic test_run_periodic();
    int last_c, n_ov;
    bit seen;
    last_c = 0; n_ov = 0; seen = 0;
    step(1'b1, 1'b1, 3'b011, iv_ph);
    for (int i = 0; i < 150; i++) begin
      iv_ph = ~iv_ph;
      step(1'b1, 1'b0, 3'b000, iv_ph);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t2_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      if (comb_en === 1'b1) begin
        if (seen) begin
          checks++;
          if (cyc - last_c != 16) begin failures++; $display("FAIL t2_period got=%0d exp=16", cyc - last_c); end
        end
        seen = 1;
        last_c = cyc;
      end
      if (m_st == 3) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy got=%b exp=0", busy); end
      end
      if (out_valid === 1'b1) n_ov++;
    end
    checks++;
    if (n_ov < 2) begin failures++; $display("FAIL t2_ov_count got=%0d exp>=2", n_ov); end
  endtask

  task automatic test_illegal_cfg();
    iv_ph = ~iv_ph;
    step(1'b1, 1'b1, 3'b111, iv_ph);
    checks++;
    if (cfg_ack !== 1'b1 || cfg_err !== 1'b1 || state !== 2'd3 || os_sel !== 3'b011) begin
      failures++;
      $display("FAIL t3_illegal ack=%b err=%b state=%0d os_sel=%b exp ack=1 err=1 state=3 os_sel=011", cfg_ack, cfg_err, state, os_sel);
    end
    for (int i = 0; i < 40; i++) begin
      iv_ph = ~iv_ph;
      step(1'b1, 1'b0, 3'b000, iv_ph);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t3_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
    end
    step(1'b1, 1'b1, 3'b001, 1'b1);
    checks++;
    if (cfg_err !== 1'b0 || state !== 2'd1 || os_sel !== 3'b000) begin
      failures++; $display("FAIL t3_legal err=%b state=%0d os_sel=%b exp err=0 state=1 os_sel=000", cfg_err, state, os_sel);
    end
  endtask

  task automatic test_cfg_on_comb();
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1'b1, 1'b0, 3'b000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t4_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      if (m_st == 3 && m_comb) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL t4_reach_run got=0 exp=1"); end
    step(1'b1, 1'b1, 3'b001, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || os_sel !== 3'b000 || state !== 2'd1) begin
      failures++; $display("FAIL t4_drop ov=%b os_sel=%b state=%0d exp ov=0 os_sel=000 state=1", out_valid, os_sel, state);
    end
  endtask

  task automatic test_en_drop();
    int n_fl, n_comb;
    bit got_ov;
    n_fl = 1; n_comb = 0; got_ov = 0;
    for (int i = 0; i < 20 && m_st != 2; i++) step(1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b0, 1'b0, 3'b000, 1'b1);
    checks++;
    if (state !== 2'd0 || os_sel !== 3'b000) begin
      failures++; $display("FAIL t5_idle state=%0d os_sel=%b exp state=0 os_sel=000", state, os_sel);
    end
    step(1'b1, 1'b0, 3'b000, 1'b1);
    checks++;
    if (state !== 2'd1) begin failures++; $display("FAIL t5_reflush state=%0d exp=1", state); end
    for (int i = 0; i < 10 && state === 2'd1; i++) begin
      step(1'b1, 1'b0, 3'b000, 1'b1);
      if (state === 2'd1) n_fl++;
    end
    checks++;
    if (n_fl != FLUSH_CYC) begin failures++; $display("FAIL t5_flush_len got=%0d exp=%0d", n_fl, FLUSH_CYC); end
    for (int i = 0; i < 60 && !got_ov; i++) begin
      if (comb_en === 1'b1) n_comb++;
      step(1'b1, 1'b0, 3'b000, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL t5_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
      if (out_valid === 1'b1) got_ov = 1;
    end
    checks++;
    if (!got_ov || n_comb != NSTG * DM + 1) begin
      failures++; $display("FAIL t5_settle_combs got_ov=%0d combs=%0d exp got_ov=1 combs=%0d", got_ov, n_comb, NSTG * DM + 1);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 60 && m_st != 3; i++) step(1'b1, 1'b0, 3'b000, 1'b1);
    repeat (3) step(1'b1, 1'b0, 3'b000, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 10'b0) begin failures++; $display("FAIL t6_async got=%b exp=%b", dut_vec, 10'b0); end
    model_reset();
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 3'b000, 1'b1);
      checks++;
      if (state !== 2'd0 || dut_vec !== exp_vec()) begin
        failures++; $display("FAIL t6_stay_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic e, r, v;
    logic [2:0] c;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 99) < 96);
      r = ($urandom_range(0, 99) < 2);
      c = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 99) < 75);
      step(e, r, c, v);
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_flush_settle();
    test_run_periodic();
    test_illegal_cfg();
    test_cfg_on_comb();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
